keccak_squeeze: RTL and testbench

//  Output (squeeze) end of the Keccak core. Accepts a post-permutation 5x5x64 state

---
 rtl/keccak_squeeze.sv | 106 ++++++++++
 tb/tb_keccak_squeeze.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/keccak_squeeze.sv
`default_nettype none
// ============================================================================
// Module      : keccak_squeeze
// Description : Squeeze stage of the Keccak core. Snapshots a permuted state,
//               streams its rate lanes as 64-bit words and asks for more
//               permutations when the digest outgrows the rate.
// Revision    : 1.0 - initial release
// ============================================================================
module keccak_squeeze #(
    parameter int RATE_LANES = 17,
    parameter int OUT_LANES  = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   state_valid,
    output logic                   state_ready,
    input  logic [4:0][4:0][63:0]  state_in,
    output logic                   perm_req,
    input  logic                   perm_done,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [63:0]            out_data,
    output logic                   out_last,
    output logic                   busy
);

    localparam int              WCW         = $clog2(OUT_LANES + 1);
    localparam logic [1:0]      c_IDLE      = 2'd0;
    localparam logic [1:0]      c_EMIT      = 2'd1;
    localparam logic [1:0]      c_PERM      = 2'd2;
    localparam logic [4:0]      c_LAST_LANE = 5'(RATE_LANES - 1);
    localparam logic [WCW-1:0]  c_LAST_WORD = WCW'(OUT_LANES - 1);

    logic [1:0]              r_state;
    logic [4:0]              r_lane_idx;
    logic [2:0]              r_x;
    logic [2:0]              r_y;
    logic [WCW-1:0]          r_word_cnt;
    logic [4:0][4:0][63:0]   r_snap;
    logic                    w_last_word;

    // r_x/r_y track lane_idx%5 and lane_idx/5 so no divider is needed
    assign w_last_word = (r_word_cnt == c_LAST_WORD);
    assign state_ready = (r_state == c_IDLE);
    assign busy        = (r_state != c_IDLE);
    assign out_valid   = (r_state == c_EMIT);
    assign perm_req    = (r_state == c_PERM);
    assign out_last    = (r_state == c_EMIT) && w_last_word;
    assign out_data    = r_snap[r_x][r_y];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_IDLE;
            r_lane_idx <= '0;
            r_x        <= '0;
            r_y        <= '0;
            r_word_cnt <= '0;
            r_snap     <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (state_valid) begin
                        r_snap     <= state_in;
                        r_lane_idx <= '0;
                        r_x        <= '0;
                        r_y        <= '0;
                        r_word_cnt <= '0;
                        r_state    <= c_EMIT;
                    end
                end
                c_EMIT: begin
                    if (out_ready) begin
                        if (w_last_word) begin
                            r_state <= c_IDLE;
                        end else begin
                            r_word_cnt <= r_word_cnt + 1'b1;
                            if (r_lane_idx == c_LAST_LANE) begin
                                r_state <= c_PERM;
                            end else begin
                                r_lane_idx <= r_lane_idx + 5'd1;
                                if (r_x == 3'd4) begin
                                    r_x <= '0;
                                    r_y <= r_y + 3'd1;
                                end else begin
                                    r_x <= r_x + 3'd1;
                                end
                            end
                        end
                    end
                end
                c_PERM: begin
                    if (perm_done) begin
                        r_snap     <= state_in;
                        r_lane_idx <= '0;
                        r_x        <= '0;
                        r_y        <= '0;
                        r_state    <= c_EMIT;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_keccak_squeeze.sv
`default_nettype none
// ============================================================================
// Module      : tb_keccak_squeeze
// Description : Directed bench for keccak_squeeze in three rate/length setups.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_keccak_squeeze;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  sv   [3];
    logic                  pd   [3];
    logic                  ordy [3];
    logic                  sr   [3];
    logic                  pr   [3];
    logic                  ov   [3];
    logic                  ol   [3];
    logic                  bz   [3];
    logic [63:0]           od   [3];
    logic [4:0][4:0][63:0] st   [3];

    int total = 0;
    int bad   = 0;
    int ep    = 0;
    logic prq = 1'b0;

    always #5 clk = ~clk;

    keccak_squeeze #(.RATE_LANES(17), .OUT_LANES(4)) dut_a (
        .clk(clk), .rst(rst), .state_valid(sv[0]), .state_ready(sr[0]),
        .state_in(st[0]), .perm_req(pr[0]), .perm_done(pd[0]),
        .out_valid(ov[0]), .out_ready(ordy[0]), .out_data(od[0]),
        .out_last(ol[0]), .busy(bz[0]));

    keccak_squeeze #(.RATE_LANES(21), .OUT_LANES(25)) dut_b (
        .clk(clk), .rst(rst), .state_valid(sv[1]), .state_ready(sr[1]),
        .state_in(st[1]), .perm_req(pr[1]), .perm_done(pd[1]),
        .out_valid(ov[1]), .out_ready(ordy[1]), .out_data(od[1]),
        .out_last(ol[1]), .busy(bz[1]));

    keccak_squeeze #(.RATE_LANES(1), .OUT_LANES(3)) dut_c (
        .clk(clk), .rst(rst), .state_valid(sv[2]), .state_ready(sr[2]),
        .state_in(st[2]), .perm_req(pr[2]), .perm_done(pd[2]),
        .out_valid(ov[2]), .out_ready(ordy[2]), .out_data(od[2]),
        .out_last(ol[2]), .busy(bz[2]));

    // count perm_req rising edges of the RATE=1 instance
    always @(negedge clk) begin
        if (!rst && pr[2] && !prq) ep = ep + 1;
        prq = pr[2];
    end

    typedef struct {
        logic [63:0] base;
        logic        sv, pd, ordy;
        logic        e_ov;
        logic [63:0] e_data;
        logic        dchk, e_last, e_sr, e_pr, e_bz;
    } vec_t;

    vec_t tbl [16];

    function automatic logic [4:0][4:0][63:0] fill(input logic [63:0] base);
        logic [4:0][4:0][63:0] s;
        s = '0;
        for (int i = 0; i < 25; i++) s[i % 5][i / 5] = base + 64'(i);
        return s;
    endfunction

    function automatic vec_t idl(input logic [63:0] b, input logic s, input logic p,
                                 input logic r, input logic dc);
        vec_t v;
        v = '{b, s, p, r, 1'b0, 64'h0, dc, 1'b0, 1'b1, 1'b0, 1'b0};
        return v;
    endfunction

    function automatic vec_t emt(input logic [63:0] b, input logic s, input logic p,
                                 input logic r, input logic [63:0] d, input logic l);
        vec_t v;
        v = '{b, s, p, r, 1'b1, d, 1'b1, l, 1'b0, 1'b0, 1'b1};
        return v;
    endfunction

    task automatic cmp(input string nm, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, got, exp);
        end
    endtask

    task automatic chk(input int k, input string nm, input logic e_ov,
                       input logic [63:0] e_d, input logic dchk, input logic e_last,
                       input logic e_sr, input logic e_pr, input logic e_bz);
        cmp({nm, ".out_valid"}, 64'(ov[k]), 64'(e_ov));
        if (dchk) cmp({nm, ".out_data"}, od[k], e_d);
        cmp({nm, ".out_last"}, 64'(ol[k]), 64'(e_last));
        cmp({nm, ".state_ready"}, 64'(sr[k]), 64'(e_sr));
        cmp({nm, ".perm_req"}, 64'(pr[k]), 64'(e_pr));
        cmp({nm, ".busy"}, 64'(bz[k]), 64'(e_bz));
    endtask

    task automatic drv(input int k, input logic s, input logic p, input logic r,
                       input logic [63:0] base);
        sv[k]   = s;
        pd[k]   = p;
        ordy[k] = r;
        st[k]   = fill(base);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int k = 0; k < 3; k++) drv(k, 1'b0, 1'b0, 1'b0, 64'h0);

        // rate 17, 4 words: clean run, then backpressure with spurious inputs
        tbl[0]  = idl(64'h1000, 1'b0, 1'b1, 1'b1, 1'b1);
        tbl[1]  = idl(64'h1000, 1'b1, 1'b0, 1'b1, 1'b1);
        tbl[2]  = emt(64'h1000, 1'b0, 1'b0, 1'b1, 64'h1000, 1'b0);
        tbl[3]  = emt(64'h1000, 1'b0, 1'b0, 1'b1, 64'h1001, 1'b0);
        tbl[4]  = emt(64'h1000, 1'b0, 1'b0, 1'b1, 64'h1002, 1'b0);
        tbl[5]  = emt(64'h1000, 1'b0, 1'b0, 1'b1, 64'h1003, 1'b1);
        tbl[6]  = idl(64'h1000, 1'b1, 1'b0, 1'b1, 1'b0);
        tbl[7]  = emt(64'h5000, 1'b1, 1'b1, 1'b1, 64'h1000, 1'b0);
        tbl[8]  = emt(64'h5000, 1'b1, 1'b1, 1'b1, 64'h1001, 1'b0);
        tbl[9]  = emt(64'h5000, 1'b1, 1'b1, 1'b0, 64'h1002, 1'b0);
        tbl[10] = emt(64'h5000, 1'b1, 1'b1, 1'b0, 64'h1002, 1'b0);
        tbl[11] = emt(64'h5000, 1'b1, 1'b1, 1'b0, 64'h1002, 1'b0);
        tbl[12] = emt(64'h5000, 1'b1, 1'b1, 1'b1, 64'h1002, 1'b0);
        tbl[13] = emt(64'h5000, 1'b1, 1'b1, 1'b1, 64'h1003, 1'b1);
        tbl[14] = idl(64'h1000, 1'b0, 1'b0, 1'b1, 1'b0);
        tbl[15] = idl(64'h1000, 1'b0, 1'b0, 1'b1, 1'b0);

        tick();
        tick();
        rst = 1'b0;
        for (int k = 0; k < 3; k++)
            chk(k, $sformatf("reset%0d", k), 1'b0, 64'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);

        for (int i = 0; i < 16; i++) begin
            chk(0, $sformatf("row%0d", i), tbl[i].e_ov, tbl[i].e_data, tbl[i].dchk,
                tbl[i].e_last, tbl[i].e_sr, tbl[i].e_pr, tbl[i].e_bz);
            drv(0, tbl[i].sv, tbl[i].pd, tbl[i].ordy, tbl[i].base);
            tick();
        end

        // abort with rst after word 1, then a fresh digest from lane 0
        drv(0, 1'b1, 1'b0, 1'b1, 64'h1000);
        tick();
        drv(0, 1'b0, 1'b0, 1'b1, 64'h1000);
        chk(0, "abort_w0", 1'b1, 64'h1000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        chk(0, "abort_w1", 1'b1, 64'h1001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        chk(0, "abort_w2", 1'b1, 64'h1002, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        drv(0, 1'b0, 1'b0, 1'b0, 64'h1000);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk(0, "abort_rst", 1'b0, 64'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        drv(0, 1'b1, 1'b0, 1'b1, 64'h3000);
        tick();
        for (int i = 0; i < 4; i++) begin
            drv(0, 1'b0, 1'b0, 1'b1, 64'h3000);
            chk(0, $sformatf("after_rst_w%0d", i), 1'b1, 64'h3000 + 64'(i), 1'b1,
                logic'(i == 3), 1'b0, 1'b0, 1'b1);
            tick();
        end
        chk(0, "after_rst_idle", 1'b0, 64'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

        // rate 21, 25 words: one permutation after lane 20
        drv(1, 1'b1, 1'b0, 1'b1, 64'h1000);
        tick();
        for (int i = 0; i < 21; i++) begin
            drv(1, 1'b0, 1'b0, 1'b1, 64'h1000);
            chk(1, $sformatf("shake_a%0d", i), 1'b1, 64'h1000 + 64'(i), 1'b1,
                1'b0, 1'b0, 1'b0, 1'b1);
            tick();
        end
        for (int i = 0; i < 5; i++) begin
            if (i == 4) drv(1, 1'b0, 1'b1, 1'b1, 64'h2000);
            else        drv(1, 1'b1, 1'b0, 1'b1, 64'h7000);
            chk(1, $sformatf("shake_perm%0d", i), 1'b0, 64'h0, 1'b0, 1'b0,
                1'b0, 1'b1, 1'b1);
            tick();
        end
        for (int i = 0; i < 4; i++) begin
            drv(1, 1'b0, 1'b0, 1'b1, 64'h7000);
            chk(1, $sformatf("shake_b%0d", i), 1'b1, 64'h2000 + 64'(i), 1'b1,
                logic'(i == 3), 1'b0, 1'b0, 1'b1);
            tick();
        end
        chk(1, "shake_idle", 1'b0, 64'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

        // rate 1, 3 words: PERM between every word, perm_done on first PERM cycle
        drv(2, 1'b1, 1'b0, 1'b1, 64'h1000);
        tick();
        for (int i = 0; i < 3; i++) begin
            drv(2, 1'b0, 1'b0, 1'b1, 64'h1000);
            chk(2, $sformatf("r1_w%0d", i), 1'b1, 64'h1000 * 64'(i + 1), 1'b1,
                logic'(i == 2), 1'b0, 1'b0, 1'b1);
            tick();
            if (i < 2) begin
                drv(2, 1'b0, 1'b1, 1'b1, 64'h1000 * 64'(i + 2));
                chk(2, $sformatf("r1_perm%0d", i), 1'b0, 64'h0, 1'b0, 1'b0,
                    1'b0, 1'b1, 1'b1);
                tick();
            end
        end
        drv(2, 1'b0, 1'b0, 1'b0, 64'h0);
        chk(2, "r1_idle", 1'b0, 64'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        cmp("r1_perm_episodes", 64'(ep), 64'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
